// File: rtl/frequency_window_monitor.sv
// Frequency window monitor.
// Classifies each frequency sample against an inclusive [LOWER_LIMIT, UPPER_LIMIT]
// window, tracks lock with separate acquire/release hysteresis, produces block
// averages, tracks sample extremes, and flags signal loss after a long sample gap.
module frequency_window_monitor #(
  parameter int unsigned LOWER_LIMIT    = 9900000,
  parameter int unsigned UPPER_LIMIT    = 10100000,
  parameter int unsigned LOCK_COUNT     = 3,
  parameter int unsigned UNLOCK_COUNT   = 2,
  parameter int unsigned AVERAGE_LOG2   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 67108864
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] frequency,
  input  logic        valid,
  input  logic        clear_minmax,
  output logic [1:0]  state,
  output logic        locked,
  output logic        in_range,
  output logic        timeout,
  output logic [31:0] average_frequency,
  output logic        average_valid,
  output logic [31:0] minimum,
  output logic [31:0] maximum,
  output logic [15:0] sample_count
);

  localparam int unsigned AccWidth   = 32 + AVERAGE_LOG2;
  // Keep the index at least one bit wide; with AVERAGE_LOG2 = 0 it stays at 0.
  localparam int unsigned IndexWidth = (AVERAGE_LOG2 == 0) ? 1 : AVERAGE_LOG2;

  localparam logic [IndexWidth-1:0] IndexLast    = IndexWidth'((1 << AVERAGE_LOG2) - 1);
  localparam logic [7:0]            LockTarget   = 8'(LOCK_COUNT);
  localparam logic [7:0]            UnlockTarget = 8'(UNLOCK_COUNT);
  localparam logic [26:0]           IdleLast     = 27'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    StNoSignal  = 2'd0,
    StAcquiring = 2'd1,
    StLocked    = 2'd2,
    StLosing    = 2'd3
  } state_e;

  state_e                state_q;
  logic [7:0]            good_count;
  logic [7:0]            bad_count;
  logic [26:0]           idle_count;
  logic [AccWidth-1:0]   accumulator;
  logic [IndexWidth-1:0] sample_index;

  logic                  sample_in_range;
  logic                  idle_expired;
  logic                  block_last;
  logic [AccWidth-1:0]   block_sum;

  assign state           = state_q;
  assign sample_in_range = (frequency >= LOWER_LIMIT) && (frequency <= UPPER_LIMIT);
  // A valid on the expiry cycle takes priority, so no timeout fires then.
  assign idle_expired    = !valid && (idle_count == IdleLast);
  assign block_last      = (sample_index == IndexLast);
  assign block_sum       = accumulator + AccWidth'(frequency);

  // Lock state machine with hysteresis counters and the registered locked flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StNoSignal;
      good_count <= 8'd0;
      bad_count  <= 8'd0;
      locked     <= 1'b0;
    end else if (valid) begin
      unique case (state_q)
        StNoSignal: begin
          if (sample_in_range) begin
            if (LockTarget == 8'd1) begin
              state_q    <= StLocked;
              good_count <= 8'd0;
              locked     <= 1'b1;
            end else begin
              state_q    <= StAcquiring;
              good_count <= 8'd1;
            end
          end
        end
        StAcquiring: begin
          if (!sample_in_range) begin
            state_q    <= StNoSignal;
            good_count <= 8'd0;
          end else if (good_count + 8'd1 == LockTarget) begin
            state_q    <= StLocked;
            good_count <= 8'd0;
            locked     <= 1'b1;
          end else begin
            good_count <= good_count + 8'd1;
          end
        end
        StLocked: begin
          if (!sample_in_range) begin
            if (UnlockTarget == 8'd1) begin
              state_q   <= StNoSignal;
              bad_count <= 8'd0;
              locked    <= 1'b0;
            end else begin
              state_q   <= StLosing;
              bad_count <= 8'd1;
            end
          end
        end
        StLosing: begin
          if (sample_in_range) begin
            state_q   <= StLocked;
            bad_count <= 8'd0;
          end else if (bad_count + 8'd1 == UnlockTarget) begin
            state_q   <= StNoSignal;
            bad_count <= 8'd0;
            locked    <= 1'b0;
          end else begin
            bad_count <= bad_count + 8'd1;
          end
        end
      endcase
    end else if (idle_expired) begin
      state_q    <= StNoSignal;
      good_count <= 8'd0;
      bad_count  <= 8'd0;
      locked     <= 1'b0;
    end
  end

  // Range flag of the most recent sample; holds between samples.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_range <= 1'b0;
    end else if (valid) begin
      in_range <= sample_in_range;
    end
  end

  // Idle gap counter; saturates at the expiry value so the loss condition persists.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idle_count <= 27'd0;
    end else if (valid) begin
      idle_count <= 27'd0;
    end else if (idle_count != IdleLast) begin
      idle_count <= idle_count + 27'd1;
    end
  end

  // Sticky signal-loss flag, released by the next sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      timeout <= 1'b0;
    end else if (valid) begin
      timeout <= 1'b0;
    end else if (idle_expired) begin
      timeout <= 1'b1;
    end
  end

  // Block averager: accumulate every sample, publish the truncated mean per block.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      accumulator       <= '0;
      sample_index      <= '0;
      average_frequency <= 32'd0;
      average_valid     <= 1'b0;
    end else if (valid) begin
      if (block_last) begin
        accumulator       <= '0;
        sample_index      <= '0;
        average_frequency <= 32'(block_sum >> AVERAGE_LOG2);
        average_valid     <= 1'b1;
      end else begin
        accumulator   <= block_sum;
        sample_index  <= sample_index + IndexWidth'(1);
        average_valid <= 1'b0;
      end
    end else begin
      average_valid <= 1'b0;
      // Signal loss restarts the block so stale samples never mix with new ones.
      if (idle_expired) begin
        accumulator  <= '0;
        sample_index <= '0;
      end
    end
  end

  // Extreme trackers; a clear coinciding with a sample seeds both with that sample.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      minimum <= 32'hFFFF_FFFF;
      maximum <= 32'd0;
    end else if (clear_minmax) begin
      minimum <= valid ? frequency : 32'hFFFF_FFFF;
      maximum <= valid ? frequency : 32'd0;
    end else if (valid) begin
      if (frequency < minimum) minimum <= frequency;
      if (frequency > maximum) maximum <= frequency;
    end
  end

  // Saturating sample counter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_count <= 16'd0;
    end else if (valid && (sample_count != 16'hFFFF)) begin
      sample_count <= sample_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_frequency_window_monitor.sv
// Bench for frequency_window_monitor: directed scenarios plus randomized samples
// checked against a run-length based reference model.
module tb_frequency_window_monitor;

  localparam int unsigned Lower   = 9900000;
  localparam int unsigned Upper   = 10100000;
  localparam int          LockN   = 3;
  localparam int          UnlockN = 2;
  localparam int          BlockN  = 4;
  localparam int          Timeout = 100;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] frequency = 32'd0;
  logic        valid = 1'b0;
  logic        clear_minmax = 1'b0;
  logic [1:0]  state;
  logic        locked;
  logic        in_range;
  logic        timeout;
  logic [31:0] average_frequency;
  logic        average_valid;
  logic [31:0] minimum;
  logic [31:0] maximum;
  logic [15:0] sample_count;

  int checks = 0;
  int errors = 0;

  frequency_window_monitor #(
    .LOWER_LIMIT   (Lower),
    .UPPER_LIMIT   (Upper),
    .LOCK_COUNT    (LockN),
    .UNLOCK_COUNT  (UnlockN),
    .AVERAGE_LOG2  (2),
    .TIMEOUT_CYCLES(Timeout)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .frequency        (frequency),
    .valid            (valid),
    .clear_minmax     (clear_minmax),
    .state            (state),
    .locked           (locked),
    .in_range         (in_range),
    .timeout          (timeout),
    .average_frequency(average_frequency),
    .average_valid    (average_valid),
    .minimum          (minimum),
    .maximum          (maximum),
    .sample_count     (sample_count)
  );

  always #5 clock = ~clock;

  // Reference model: lock described by run lengths of good/bad samples,
  // averaging by a plain running sum over a block of samples.
  bit          m_locked;
  int          m_good_run;
  int          m_bad_run;
  bit          m_in_range;
  bit          m_timeout;
  int          m_idle;
  longint      m_sum;
  int          m_n;
  logic [31:0] m_avg;
  bit          m_avg_valid;
  logic [31:0] m_min;
  logic [31:0] m_max;
  int          m_count;

  function automatic logic [1:0] m_state();
    if (m_locked) return (m_bad_run > 0) ? 2'd3 : 2'd2;
    return (m_good_run > 0) ? 2'd1 : 2'd0;
  endfunction

  task automatic model_reset();
    m_locked = 0; m_good_run = 0; m_bad_run = 0; m_in_range = 0; m_timeout = 0;
    m_idle = 0; m_sum = 0; m_n = 0; m_avg = 0; m_avg_valid = 0;
    m_min = 32'hFFFF_FFFF; m_max = 0; m_count = 0;
  endtask

  task automatic model_step(input bit v, input logic [31:0] f, input bit clr);
    bit ir;
    m_avg_valid = 0;
    if (v) begin
      ir = (f >= Lower) && (f <= Upper);
      m_idle = 0;
      m_timeout = 0;
      m_in_range = ir;
      if (!m_locked) begin
        m_good_run = ir ? m_good_run + 1 : 0;
        if (m_good_run >= LockN) begin
          m_locked = 1; m_good_run = 0; m_bad_run = 0;
        end
      end else begin
        m_bad_run = ir ? 0 : m_bad_run + 1;
        if (m_bad_run >= UnlockN) begin
          m_locked = 0; m_bad_run = 0; m_good_run = 0;
        end
      end
      m_sum += longint'(f);
      m_n++;
      if (m_n == BlockN) begin
        m_avg = 32'(m_sum / BlockN);
        m_avg_valid = 1;
        m_sum = 0;
        m_n = 0;
      end
      if (clr) begin
        m_min = f; m_max = f;
      end else begin
        if (f < m_min) m_min = f;
        if (f > m_max) m_max = f;
      end
      if (m_count < 65535) m_count++;
    end else begin
      if (m_idle == Timeout - 1) begin
        m_locked = 0; m_good_run = 0; m_bad_run = 0;
        m_sum = 0; m_n = 0; m_timeout = 1;
      end else begin
        m_idle++;
      end
      if (clr) begin
        m_min = 32'hFFFF_FFFF; m_max = 0;
      end
    end
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model, and
  // return at the next falling edge with the DUT outputs settled.
  task automatic cycle(input bit v, input logic [31:0] f, input bit clr);
    valid = v;
    frequency = f;
    clear_minmax = clr;
    model_step(v, f, clr);
    @(negedge clock);
  endtask

  task automatic do_reset();
    valid = 0; clear_minmax = 0; frequency = 0;
    reset_n = 0;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1, 32'd10000000, 0);
    cycle(1, 32'd10000000, 0);
    // Assert reset away from any clock edge and check it acts immediately.
    #3;
    reset_n = 0;
    valid = 0;
    model_reset();
    #1;
    checks++;
    if (state !== 2'd0 || locked !== 1'b0 || in_range !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got state=%0d locked=%0b in_range=%0b timeout=%0b expected 0 0 0 0",
               state, locked, in_range, timeout);
    end
    checks++;
    if (average_frequency !== 32'd0 || average_valid !== 1'b0 || sample_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_avg_count: got avg=%0d avg_valid=%0b count=%0d expected 0 0 0",
               average_frequency, average_valid, sample_count);
    end
    checks++;
    if (minimum !== 32'hFFFF_FFFF || maximum !== 32'd0) begin
      errors++;
      $display("FAIL reset_minmax: got min=%h max=%h expected ffffffff 00000000", minimum, maximum);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;
  endtask

  task automatic test_lock();
    logic [1:0] exp_state [3] = '{2'd1, 2'd1, 2'd2};
    logic       exp_lock  [3] = '{1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'd10000000, 0);
      checks++;
      if (state !== exp_state[i] || locked !== exp_lock[i]) begin
        errors++;
        $display("FAIL lock_step%0d: got state=%0d locked=%0b expected %0d %0b",
                 i, state, locked, exp_state[i], exp_lock[i]);
      end
    end
  endtask

  task automatic test_unlock();
    logic [31:0] f_seq     [4] = '{32'd12000000, 32'd10000000, 32'd12000000, 32'd12000000};
    logic [1:0]  exp_state [4] = '{2'd3, 2'd2, 2'd3, 2'd0};
    logic        exp_lock  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cycle(1, f_seq[i], 0);
      checks++;
      if (state !== exp_state[i] || locked !== exp_lock[i]) begin
        errors++;
        $display("FAIL unlock_step%0d: got state=%0d locked=%0b expected %0d %0b",
                 i, state, locked, exp_state[i], exp_lock[i]);
      end
    end
  endtask

  task automatic test_average();
    logic [31:0] f_seq [4] = '{32'd10, 32'd11, 32'd12, 32'd14};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, f_seq[i], 0);
      checks++;
      if (average_valid !== (i == 3)) begin
        errors++;
        $display("FAIL average_pulse%0d: got %0b expected %0b", i, average_valid, (i == 3));
      end
    end
    checks++;
    if (average_frequency !== 32'd11) begin
      errors++;
      $display("FAIL average_value: got %0d expected 11", average_frequency);
    end
    cycle(0, 32'd0, 0);
    checks++;
    if (average_valid !== 1'b0 || average_frequency !== 32'd11) begin
      errors++;
      $display("FAIL average_hold: got valid=%0b avg=%0d expected 0 11",
               average_valid, average_frequency);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 32'd10000000, 0);
    for (int i = 0; i < Timeout - 1; i++) cycle(0, 32'd0, 0);
    checks++;
    if (state !== 2'd2 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got state=%0d timeout=%0b expected 2 0", state, timeout);
    end
    cycle(0, 32'd0, 0);
    checks++;
    if (state !== 2'd0 || timeout !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: got state=%0d timeout=%0b locked=%0b expected 0 1 0",
               state, timeout, locked);
    end
    for (int i = 0; i < 5; i++) cycle(0, 32'd0, 0);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: got %0b expected 1", timeout);
    end
    cycle(1, 32'd10000000, 0);
    checks++;
    if (state !== 2'd1 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: got state=%0d timeout=%0b expected 1 0", state, timeout);
    end
  endtask

  task automatic test_minmax();
    do_reset();
    cycle(1, 32'd5, 0);
    cycle(1, 32'd9, 0);
    cycle(1, 32'd3, 0);
    checks++;
    if (minimum !== 32'd3 || maximum !== 32'd9) begin
      errors++;
      $display("FAIL minmax_track: got min=%0d max=%0d expected 3 9", minimum, maximum);
    end
    cycle(1, 32'd7, 1);
    checks++;
    if (minimum !== 32'd7 || maximum !== 32'd7) begin
      errors++;
      $display("FAIL minmax_clear_valid: got min=%0d max=%0d expected 7 7", minimum, maximum);
    end
    cycle(0, 32'd0, 1);
    checks++;
    if (minimum !== 32'hFFFF_FFFF || maximum !== 32'd0) begin
      errors++;
      $display("FAIL minmax_clear: got min=%h max=%h expected ffffffff 00000000", minimum, maximum);
    end
  endtask

  task automatic test_boundaries();
    logic [31:0] f_seq [4] = '{32'd9900000, 32'd10100000, 32'd9899999, 32'd10100001};
    logic        exp_ir [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, f_seq[i], 0);
      checks++;
      if (in_range !== exp_ir[i]) begin
        errors++;
        $display("FAIL boundary_%0d: got in_range=%0b expected %0b", f_seq[i], in_range, exp_ir[i]);
      end
    end
    cycle(1, 32'd10000000, 0);
    cycle(0, 32'd0, 0);
    checks++;
    if (in_range !== 1'b1) begin
      errors++;
      $display("FAIL in_range_hold: got %0b expected 1", in_range);
    end
  endtask

  task automatic test_reset_midway();
    do_reset();
    cycle(1, 32'd100, 0);
    cycle(1, 32'd200, 0);
    // Drop reset mid-block and mid-acquisition; the partial block must vanish.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1, 32'd40 + 32'(i), 0);
      checks++;
      if (average_valid !== (i == 3) || state !== ((i == 0) ? 2'd0 : 2'd0)) begin
        errors++;
        $display("FAIL reset_midway_pulse%0d: got valid=%0b state=%0d expected %0b 0",
                 i, average_valid, state, (i == 3));
      end
    end
    checks++;
    if (average_frequency !== 32'd41) begin
      errors++;
      $display("FAIL reset_midway_avg: got %0d expected 41", average_frequency);
    end
  endtask

  task automatic test_random();
    bit          v;
    bit          clr;
    logic [31:0] f;
    int          gap;
    do_reset();
    gap = 0;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 9) < 7) || (gap >= 3);
      clr = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) f = $urandom();
      else f = $urandom_range(Upper + 20000, Lower - 20000);
      gap = v ? 0 : gap + 1;
      cycle(v, f, clr);
      checks++;
      if (state !== m_state() || locked !== m_locked || in_range !== m_in_range
          || timeout !== m_timeout) begin
        errors++;
        $display("FAIL random_lock[%0d]: got st=%0d lk=%0b ir=%0b to=%0b expected %0d %0b %0b %0b",
                 i, state, locked, in_range, timeout, m_state(), m_locked, m_in_range, m_timeout);
      end
      checks++;
      if (average_valid !== m_avg_valid || average_frequency !== m_avg) begin
        errors++;
        $display("FAIL random_avg[%0d]: got valid=%0b avg=%0d expected %0b %0d",
                 i, average_valid, average_frequency, m_avg_valid, m_avg);
      end
      checks++;
      if (minimum !== m_min || maximum !== m_max || sample_count !== 16'(m_count)) begin
        errors++;
        $display("FAIL random_minmax[%0d]: got min=%0d max=%0d cnt=%0d expected %0d %0d %0d",
                 i, minimum, maximum, sample_count, m_min, m_max, m_count);
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_lock();
    test_unlock();
    test_average();
    test_timeout();
    test_minmax();
    test_boundaries();
    test_reset_midway();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
